// File: rtl/div_sched_pkg.sv
// Shared types, constants and helpers for the divider scheduler.
package div_sched_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StSpecial,
    StIssue,
    StWait,
    StResp
  } state_e;

  function automatic logic is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// Requester and divider-core signal bundle for div_scheduler.
interface div_scheduler_if;
  import div_sched_pkg::*;

  logic [1:0]            req_valid_i;
  logic [1:0]            req_ready_o;
  logic [1:0][1:0]       req_op_i;
  logic [1:0][XLEN-1:0]  req_a_i;
  logic [1:0][XLEN-1:0]  req_b_i;
  logic [1:0][TAG_W-1:0] req_tag_i;

  logic [1:0]            resp_valid_o;
  logic [1:0]            resp_ready_i;
  logic [XLEN-1:0]       resp_data_o;
  logic [TAG_W-1:0]      resp_tag_o;

  logic                  div_in_valid_o;
  logic                  div_in_ready_i;
  logic [XLEN-1:0]       div_a_o;
  logic [XLEN-1:0]       div_b_o;
  logic                  div_out_valid_i;
  logic                  div_out_ready_o;
  logic [XLEN-1:0]       div_q_i;
  logic [XLEN-1:0]       div_r_i;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, resp_ready_i,
           div_in_ready_i, div_out_valid_i, div_q_i, div_r_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_tag_o,
           div_in_valid_o, div_a_o, div_b_o, div_out_ready_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i, resp_ready_i,
           div_in_ready_i, div_out_valid_i, div_q_i, div_r_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_tag_o,
           div_in_valid_o, div_a_o, div_b_o, div_out_ready_o
  );

endinterface

// File: rtl/div_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes away from last_grant.
module div_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = (valid == 2'b11) ? ~last_grant : valid[1];
  end

endmodule

// File: rtl/div_scheduler.sv
// Shares one unsigned iterative divider between two requesters, handling RV32M
// sign fix-up, divide-by-zero and signed overflow without the core.
module div_scheduler
  import div_sched_pkg::*;
(
  input logic            clock,
  input logic            nreset,
  div_scheduler_if.slave bus
);

  state_e             state_q;
  div_op_e            op_q;
  logic [XLEN-1:0]    a_q, b_q, result_q;
  logic [TAG_W-1:0]   tag_q;
  logic               id_q, last_grant_q;
  logic [1:0]         resp_valid_q;
  logic               div_in_valid_q;

  logic               grant_valid, grant_id;
  div_op_e            sel_op;
  logic [XLEN-1:0]    sel_a, sel_b;
  logic               sel_special;
  logic               op_signed;
  logic [XLEN-1:0]    q_fix, r_fix, special_res;

  div_rr_arb2 u_arb (
    .valid       (bus.req_valid_i),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_op      = div_op_e'(bus.req_op_i[grant_id]);
    sel_a       = bus.req_a_i[grant_id];
    sel_b       = bus.req_b_i[grant_id];
    sel_special = (sel_b == '0) || (is_signed(sel_op) && (sel_a == INT_MIN) && (sel_b == '1));
  end

  always_comb begin
    bus.req_ready_o = '0;
    if ((state_q == StIdle) && grant_valid) bus.req_ready_o[grant_id] = 1'b1;
  end

  assign op_signed = is_signed(op_q);

  // INT_MIN negates to itself, which the core reads as the unsigned 2^31.
  assign bus.div_a_o = (op_signed && a_q[XLEN-1]) ? -a_q : a_q;
  assign bus.div_b_o = (op_signed && b_q[XLEN-1]) ? -b_q : b_q;

  always_comb begin
    q_fix = (op_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -bus.div_q_i : bus.div_q_i;
    r_fix = (op_signed && a_q[XLEN-1]) ? -bus.div_r_i : bus.div_r_i;
    if (b_q == '0) special_res = is_rem(op_q) ? a_q : '1;
    else           special_res = is_rem(op_q) ? '0 : a_q;
  end

  assign bus.div_in_valid_o  = div_in_valid_q;
  assign bus.div_out_ready_o = (state_q == StWait);
  assign bus.resp_valid_o    = resp_valid_q;
  assign bus.resp_data_o     = result_q;
  assign bus.resp_tag_o      = tag_q;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q        <= StIdle;
      op_q           <= DIV;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      tag_q          <= '0;
      id_q           <= 1'b0;
      last_grant_q   <= 1'b1;
      resp_valid_q   <= '0;
      div_in_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            op_q         <= sel_op;
            a_q          <= sel_a;
            b_q          <= sel_b;
            tag_q        <= bus.req_tag_i[grant_id];
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            if (sel_special) begin
              state_q <= StSpecial;
            end else begin
              state_q        <= StIssue;
              div_in_valid_q <= 1'b1;
            end
          end
        end
        StSpecial: begin
          result_q     <= special_res;
          resp_valid_q <= id_q ? 2'b10 : 2'b01;
          state_q      <= StResp;
        end
        StIssue: begin
          if (bus.div_in_ready_i) begin
            div_in_valid_q <= 1'b0;
            state_q        <= StWait;
          end
        end
        StWait: begin
          if (bus.div_out_valid_i) begin
            result_q     <= is_rem(op_q) ? r_fix : q_fix;
            resp_valid_q <= id_q ? 2'b10 : 2'b01;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (bus.resp_ready_i[id_q]) begin
            resp_valid_q <= '0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
